adc_emulator: RTL and testbench

- Synthesizable model of the 8-channel, 8-bit parallel-bus ADC that the sampler drives. It is the responder side of the n_convst / n_eoc / n_cs / n_rd handshake.
- Generates deterministic per-channel ramp data so the sampler and the downstream beamforming path can be loopback-tested on the FPGA without the physical ADC.
- Also usable as a bench model.

---
 rtl/adc_emulator.sv | 142 ++++++++++++++
 tb/tb_adc_emulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_emulator.sv
// adc_emulator: responder side of the n_convst / n_eoc / n_cs / n_rd parallel ADC
// handshake. Produces deterministic per-channel ramp data so the sampler and the
// downstream path can be exercised without the physical converter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no conversion pending, n_eoc high
// CONVERT | counting down CONV_CYCLES, n_eoc high
// DONE    | result registered, n_eoc low until a read strobe
module adc_emulator #(
    parameter int unsigned CONV_CYCLES = 20,
    parameter logic [7:0]  RAMP_STEP   = 8'd3,
    parameter logic [7:0]  CH_OFFSET   = 8'd32
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [2:0] chnl,
    input  logic       n_convst,
    input  logic       n_cs,
    input  logic       n_rd,
    output logic       n_eoc,
    output logic [7:0] adc_out,
    output logic       adc_oe,
    output logic       err_overrun,
    output logic       err_stale
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [7:0] CONV_LOAD = CONV_CYCLES[7:0];

    state_t     state;
    logic [7:0] conv_cnt;
    logic [7:0] data_reg;
    logic [7:0] ramp;
    logic [2:0] ch_lat;

    // bit 0 = first sync flop, bit 1 = second sync flop, bit 2 = history
    logic [2:0] convst_sh;
    logic [2:0] cs_sh;
    logic [2:0] rd_sh;

    logic       convst_fall;
    logic       rd_now;
    logic       rd_prev;
    logic       rd_strobe;
    logic [7:0] ch_ext;
    logic [7:0] conv_value;

    assign convst_fall = ~convst_sh[1] & convst_sh[2];
    assign rd_now      = ~cs_sh[1] & ~rd_sh[1];
    assign rd_prev     = ~cs_sh[2] & ~rd_sh[2];
    assign rd_strobe   = rd_now & ~rd_prev;

    assign ch_ext      = {5'b00000, ch_lat};
    assign conv_value  = ramp + ch_ext * CH_OFFSET;

    // Bus enable straight from the pins so read access time is not delayed by the synchronizers
    assign adc_oe  = ~n_cs & ~n_rd;
    assign adc_out = adc_oe ? data_reg : 8'h00;

    // Two-flop synchronizers plus a history flop for edge detection on each strobe
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            convst_sh <= 3'b111;
            cs_sh     <= 3'b111;
            rd_sh     <= 3'b111;
        end else begin
            convst_sh <= {convst_sh[1:0], n_convst};
            cs_sh     <= {cs_sh[1:0], n_cs};
            rd_sh     <= {rd_sh[1:0], n_rd};
        end
    end

    // Conversion sequencer: start, countdown, result capture, read handshake and error flags
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            n_eoc       <= 1'b1;
            conv_cnt    <= 8'd0;
            data_reg    <= 8'd0;
            ramp        <= 8'd0;
            ch_lat      <= 3'd0;
            err_overrun <= 1'b0;
            err_stale   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_strobe) begin
                        err_stale <= 1'b1;
                    end
                    if (convst_fall) begin
                        ch_lat   <= chnl;
                        conv_cnt <= CONV_LOAD;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    // A second start request is dropped; the running conversion is unaffected
                    if (convst_fall) begin
                        err_overrun <= 1'b1;
                    end
                    if (rd_strobe) begin
                        err_stale <= 1'b1;
                    end
                    if (conv_cnt == 8'd1) begin
                        data_reg <= conv_value;
                        n_eoc    <= 1'b0;
                        if (ch_lat == 3'd0) begin
                            ramp <= ramp + RAMP_STEP;
                        end
                        state <= DONE;
                    end else begin
                        conv_cnt <= conv_cnt - 8'd1;
                    end
                end
                DONE: begin
                    if (rd_strobe) begin
                        n_eoc <= 1'b1;
                        state <= IDLE;
                    end
                    // A new start here wins over the return to IDLE; unread data is simply replaced later
                    if (convst_fall) begin
                        n_eoc    <= 1'b1;
                        ch_lat   <= chnl;
                        conv_cnt <= CONV_LOAD;
                        state    <= CONVERT;
                    end
                end
                default: begin
                    state <= IDLE;
                    n_eoc <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_emulator.sv
// Testbench for adc_emulator: randomized conversions and reads checked by a
// scoreboard fed from a ramp/offset reference model, plus latency, overrun,
// stale-read, simultaneous-event and reset checks.
module tb_adc_emulator;

    localparam int CONV = 20;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [2:0] chnl;
    logic       n_convst;
    logic       n_cs;
    logic       n_rd;
    logic       n_eoc;
    logic [7:0] adc_out;
    logic       adc_oe;
    logic       err_overrun;
    logic       err_stale;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int ramp_m = 0;
    int data_m = 0;
    logic oe_prev = 1'b0;
    bit in_done = 1'b0;

    adc_emulator #(
        .CONV_CYCLES(CONV),
        .RAMP_STEP  (8'd3),
        .CH_OFFSET  (8'd32)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .chnl       (chnl),
        .n_convst   (n_convst),
        .n_cs       (n_cs),
        .n_rd       (n_rd),
        .n_eoc      (n_eoc),
        .adc_out    (adc_out),
        .adc_oe     (adc_oe),
        .err_overrun(err_overrun),
        .err_stale  (err_stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the data register holds ramp + ch*32 of the last completed
    // conversion; only channel-0 completions advance the ramp by 3.
    task automatic model_conv(input int ch);
        data_m = (ramp_m + ch * 32) % 256;
        if (ch == 0) ramp_m = (ramp_m + 3) % 256;
    endtask

    // Monitor: every new bus drive pops one expected value; an idle bus must read 0
    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            if (adc_oe && !oe_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL read_unexpected: got %0d, expected no read", adc_out);
                end else begin
                    check("read_data", int'(adc_out), exp_q.pop_front());
                end
            end else if (!adc_oe) begin
                check("bus_idle", int'(adc_out), 0);
            end
        end
        oe_prev = adc_oe;
    end

    // One conversion; edge 0 is the first posedge sampling n_convst low.
    // Optionally a second start 5 cycles in (overrun) or a read issued together with the start.
    task automatic conv_timed(input int ch, input bit ovr, input int ovr_ch, input bit with_read);
        @(posedge clk); #1;
        chnl = 3'(ch);
        n_convst = 1'b0;
        if (with_read) begin
            n_cs = 1'b0;
            n_rd = 1'b0;
            exp_q.push_back(data_m);
        end
        for (int k = 0; k <= 2 + CONV; k++) begin
            @(posedge clk); #1;
            if (k == 1) n_convst = 1'b1;
            if (ovr && k == 5) begin
                chnl = 3'(ovr_ch);
                n_convst = 1'b0;
            end
            if (ovr && k == 7) n_convst = 1'b1;
            if (with_read && k == 2) check("simul_eoc_high", int'(n_eoc), 1);
            if (with_read && k == 3) begin
                n_cs = 1'b1;
                n_rd = 1'b1;
            end
            if (k == 1 + CONV) check("eoc_not_early", int'(n_eoc), 1);
        end
        check("eoc_latency", int'(n_eoc), 0);
        model_conv(ch);
        in_done = 1'b1;
    endtask

    task automatic do_read();
        @(posedge clk); #1;
        n_cs = 1'b0;
        n_rd = 1'b0;
        exp_q.push_back(data_m);
        repeat (3) @(posedge clk);
        #1;
        check("eoc_after_read", int'(n_eoc), 1);
        n_cs = 1'b1;
        n_rd = 1'b1;
        repeat (4) @(posedge clk);
        in_done = 1'b0;
    endtask

    initial begin
        n_reset  = 1'b0;
        chnl     = 3'd0;
        n_convst = 1'b1;
        n_cs     = 1'b1;
        n_rd     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_n_eoc", int'(n_eoc), 1);
        check("rst_oe", int'(adc_oe), 0);
        check("rst_overrun", int'(err_overrun), 0);
        check("rst_stale", int'(err_stale), 0);
        n_reset = 1'b1;
        repeat (3) @(posedge clk);

        // Ramp and offsets: channels 1,2,3,0,1
        conv_timed(1, 0, 0, 0); do_read();
        conv_timed(2, 0, 0, 0); do_read();
        conv_timed(3, 0, 0, 0); do_read();
        conv_timed(0, 0, 0, 0); do_read();
        conv_timed(1, 0, 0, 0); do_read();

        // Randomized conversions, some left unread, some read together with the next start
        for (int i = 0; i < 30; i++) begin
            int ch;
            bit rd_with;
            ch = int'($urandom_range(0, 7));
            rd_with = in_done && ($urandom_range(0, 1) == 1);
            conv_timed(ch, 0, 0, rd_with);
            if ($urandom_range(0, 3) != 0) do_read();
        end
        if (in_done) do_read();
        check("no_overrun_yet", int'(err_overrun), 0);
        check("no_stale_yet", int'(err_stale), 0);

        // Simultaneous read and new start while in DONE
        conv_timed(6, 0, 0, 0);
        conv_timed(4, 0, 0, 1);
        do_read();
        check("simul_no_stale", int'(err_stale), 0);

        // Overrun: second start ignored, result follows first channel
        conv_timed(5, 1, 2, 0);
        check("overrun_flag", int'(err_overrun), 1);
        do_read();

        // Stale read in IDLE repeats previous data
        do_read();
        check("stale_flag", int'(err_stale), 1);

        // Reset 10 cycles into a conversion
        @(posedge clk); #1;
        chnl = 3'd3;
        n_convst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_convst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_reset = 1'b0;
        #1;
        check("reset_n_eoc", int'(n_eoc), 1);
        check("reset_overrun", int'(err_overrun), 0);
        check("reset_stale", int'(err_stale), 0);
        ramp_m = 0;
        data_m = 0;
        in_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        repeat (3) @(posedge clk);
        do_read();
        conv_timed(0, 0, 0, 0);
        do_read();

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
